// File: rtl/console_pkg.sv
// Shared constants, control codes and controller state encoding for the
// 80x25 text console write path.
package console_pkg;
    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int ADDR_W = 11;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_SCREEN
    } state_t;
endpackage

// File: rtl/text_addr_calc.sv
// Row/column to text RAM address, row*80 + col built as (row<<6)+(row<<4)+col.
module text_addr_calc
    import console_pkg::*;
(
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    output logic [ADDR_W-1:0] addr
);
    assign addr = ADDR_W'({row, 6'b0}) + ADDR_W'({row, 4'b0}) + ADDR_W'(col);
endmodule

// File: rtl/text_console_writer.sv
// Byte-stream to text RAM writer: cursor tracking, CR/LF/BS/FF handling,
// and blanking of the screen (after reset/FF) or of the row entered on wrap.
module text_console_writer
    import console_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char_data,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [ADDR_W-1:0] write_address,
    output logic [7:0]        write_data,
    output logic              write_en,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);
    state_t            state, state_n;
    logic [6:0]        col_n, clr_col, clr_col_n, calc_col;
    logic [4:0]        row_n, clr_row, clr_row_n, calc_row;
    logic [ADDR_W-1:0] calc_addr, wa_n;
    logic [7:0]        wd_n;
    logic              we_n, newline;

    text_addr_calc u_addr (
        .row  (calc_row),
        .col  (calc_col),
        .addr (calc_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CLR_SCREEN;
            cursor_col    <= '0;
            cursor_row    <= '0;
            clr_col       <= '0;
            clr_row       <= '0;
            write_en      <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            char_ready    <= 1'b0;
            busy          <= 1'b1;
        end else begin
            state         <= state_n;
            cursor_col    <= col_n;
            cursor_row    <= row_n;
            clr_col       <= clr_col_n;
            clr_row       <= clr_row_n;
            write_en      <= we_n;
            write_address <= wa_n;
            write_data    <= wd_n;
            char_ready    <= (state_n == IDLE);
            busy          <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n   = state;
        col_n     = cursor_col;
        row_n     = cursor_row;
        clr_col_n = clr_col;
        clr_row_n = clr_row;
        we_n      = 1'b0;
        wa_n      = write_address;
        wd_n      = write_data;
        newline   = 1'b0;
        calc_row  = cursor_row;
        calc_col  = cursor_col;

        // One address calculator serves both the clear walk and the cursor.
        if (state != IDLE) begin
            calc_row = clr_row;
            calc_col = clr_col;
        end else if (char_data == CH_BS) begin
            calc_col = cursor_col - 7'd1;
        end

        case (state)
            IDLE: begin
                if (char_valid && char_ready) begin
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        we_n = 1'b1;
                        wa_n = calc_addr;
                        wd_n = char_data;
                        if (cursor_col != COL_LAST) col_n = cursor_col + 7'd1;
                        else                        newline = 1'b1;
                    end else begin
                        case (char_data)
                            CH_CR: col_n = '0;
                            CH_LF: newline = 1'b1;
                            CH_BS: begin
                                if (cursor_col != '0) begin
                                    col_n = cursor_col - 7'd1;
                                    we_n  = 1'b1;
                                    wa_n  = calc_addr;
                                    wd_n  = BLANK;
                                end
                            end
                            CH_FF: begin
                                col_n     = '0;
                                row_n     = '0;
                                clr_col_n = '0;
                                clr_row_n = '0;
                                state_n   = CLR_SCREEN;
                            end
                            default: ;
                        endcase
                    end
                    if (newline) begin
                        col_n = '0;
                        if (cursor_row != ROW_LAST) begin
                            row_n = cursor_row + 5'd1;
                        end else begin
                            row_n     = '0;
                            clr_col_n = '0;
                            clr_row_n = '0;
                            state_n   = CLR_LINE;
                        end
                    end
                end
            end
            default: begin
                we_n = 1'b1;
                wa_n = calc_addr;
                wd_n = BLANK;
                if (clr_col == COL_LAST) begin
                    clr_col_n = '0;
                    // Line clear ends after one row; screen clear stops at 1999.
                    if (state == CLR_LINE || clr_row == ROW_LAST) state_n = IDLE;
                    else                                          clr_row_n = clr_row + 5'd1;
                end else begin
                    clr_col_n = clr_col + 7'd1;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: expected RAM writes are queued by
// the stimulus and popped by an independent write-port monitor.
module tb_text_console_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic [10:0] write_address;
    logic [7:0]  write_data;
    logic        write_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [18:0] exp_q[$];

    text_console_writer dut (
        .clk           (clk),
        .reset         (reset),
        .char_data     (char_data),
        .char_valid    (char_valid),
        .char_ready    (char_ready),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .cursor_col    (cursor_col),
        .cursor_row    (cursor_row),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Write-port monitor
    always @(negedge clk) begin
        logic [18:0] e;
        checks++;
        if (busy !== ~char_ready) begin
            failures++;
            $display("FAIL busy_vs_ready busy=%0b ready=%0b", busy, char_ready);
        end
        if (write_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%02h", write_address, write_data);
            end else begin
                e = exp_q.pop_front();
                if ({write_address, write_data} !== e) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%02h exp addr=%0d data=%02h",
                             write_address, write_data, e[18:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int a, input logic [7:0] d);
        exp_q.push_back({11'(a), d});
    endtask

    task automatic push_blanks(input int n);
        for (int i = 0; i < n; i++) push_exp(i, 8'h20);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (char_ready !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) chk("send_ready_timeout", 0, 1);
        char_data  = b;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || char_ready !== 1'b1) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_cursor(input string name, input int c, input int r);
        chk({name, "_col"}, 32'(cursor_col), c);
        chk({name, "_row"}, 32'(cursor_row), r);
    endtask

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        @(posedge clk); #1;
        chk("rst_write_en", 32'(write_en), 0);
        chk("rst_addr", 32'(write_address), 0);
        chk("rst_data", 32'(write_data), 0);
        chk("rst_ready", 32'(char_ready), 0);
        chk_cursor("rst_cursor", 0, 0);

        // Full-screen clear after reset: 2000 consecutive writes
        push_blanks(2000);
        reset = 1'b0;
        repeat (1000) @(posedge clk);
        #1 chk("clr_ready_mid", 32'(char_ready), 0);
        repeat (1001) @(posedge clk);
        #1;
        chk("clr_done_queue", exp_q.size(), 0);
        chk("clr_done_ready", 32'(char_ready), 1);
        chk_cursor("clr_cursor", 0, 0);

        // Back-to-back "HI"
        push_exp(0, "H");
        push_exp(1, "I");
        send("H");
        chk("hi_ready_between", 32'(char_ready), 1);
        send("I");
        chk("hi_ready_after", 32'(char_ready), 1);
        drain("hi_drain");
        chk_cursor("hi_cursor", 2, 0);

        // Line wrap
        send(8'h0D);
        chk_cursor("cr_cursor", 0, 0);
        for (int i = 0; i < 80; i++) push_exp(i, "A");
        for (int i = 0; i < 80; i++) send("A");
        drain("wrap_drain");
        chk_cursor("wrap_cursor", 0, 1);
        push_exp(80, "B");
        send("B");
        drain("b_drain");
        chk_cursor("b_cursor", 1, 1);

        // Screen wrap from (79,24)
        send(8'h0D);
        for (int i = 0; i < 23; i++) send(8'h0A);
        chk_cursor("lf_cursor", 0, 24);
        for (int i = 0; i < 79; i++) push_exp(1920 + i, "x");
        for (int i = 0; i < 79; i++) send("x");
        chk_cursor("pre_z_cursor", 79, 24);
        push_exp(1999, "Z");
        push_blanks(80);
        send("Z");
        chk("z_ready_low", 32'(char_ready), 0);
        chk("z_busy_high", 32'(busy), 1);
        chk_cursor("z_cursor_stable", 0, 0);
        drain("z_drain");
        chk_cursor("z_cursor", 0, 0);

        // Controls
        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) push_exp(240 + i, "c");
        for (int i = 0; i < 5; i++) send("c");
        chk_cursor("ctl_start", 5, 3);
        push_exp(244, 8'h20);
        send(8'h08);
        drain("bs_drain");
        chk_cursor("bs_cursor", 4, 3);
        send(8'h0D);
        chk_cursor("ctl_cr", 0, 3);
        send(8'h08);
        drain("bs0_drain");
        chk_cursor("bs0_cursor", 0, 3);
        send(8'h0A);
        chk_cursor("ctl_lf", 0, 4);
        send(8'h07);
        drain("bel_drain");
        chk_cursor("bel_cursor", 0, 4);

        // Form feed, then reset after 100 clear writes
        push_blanks(100);
        send(8'h0C);
        chk_cursor("ff_cursor", 0, 0);
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_queue", exp_q.size(), 0);
        push_blanks(2000);
        reset      = 1'b0;
        char_data  = "Q";
        char_valid = 1'b1;
        repeat (1999) @(posedge clk);
        #1 char_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_done_queue", exp_q.size(), 0);
        chk("abort_done_ready", 32'(char_ready), 1);
        chk_cursor("abort_cursor", 0, 0);
        repeat (3) @(posedge clk);
        #1 chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
